// File: rtl/cp0_exc_seq_pkg.sv
// Shared constants, field positions and state encoding for the CP0 exception sequencer.
package cp0_exc_seq_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    // Cause bits preserved from the current register value on exception entry
    localparam logic [31:0] CAUSE_KEEP = 32'h7FFF_0383;
    localparam logic [31:0] SR_EXL_MASK = 32'h0000_0002;
    localparam logic [4:0]  EXC_INT = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_E_EPC   = 3'd1,
        ST_E_CAUSE = 3'd2,
        ST_E_SR    = 3'd3,
        ST_E_JMP   = 3'd4,
        ST_R_SR    = 3'd5,
        ST_R_JMP   = 3'd6
    } state_t;

    function automatic logic [31:0] cause_merge(input logic [31:0] cause_cur,
                                                input logic        bd,
                                                input logic [5:0]  hwint,
                                                input logic [4:0]  code);
        logic [31:0] m;
        m = cause_cur & CAUSE_KEEP;
        m[CAUSE_BD] = bd;
        m[CAUSE_IP_HI:CAUSE_IP_LO] = hwint;
        m[CAUSE_EXC_HI:CAUSE_EXC_LO] = code;
        return m;
    endfunction

endpackage

// File: rtl/cp0_exc_seq_if.sv
// Signal bundle between the M-stage/CP0 request logic, the sequencer and the CP0 write port.
// mtc0 handshake: a write transfers in a cycle where mtc0_valid and mtc0_ready are both 1;
// the pipeline keeps valid, addr and data stable until then.
interface cp0_exc_seq_if;
    import cp0_exc_seq_pkg::*;

    logic        exc_req;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_vpc;
    logic [5:0]  hwint;
    logic        eret_valid;
    logic        mtc0_valid;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic        mtc0_ready;
    logic [31:0] sr_in;
    logic [31:0] cause_in;
    logic [31:0] epc_in;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        stall;
    logic        flush;
    logic        pc_redirect_vld;
    logic [31:0] pc_redirect;
    logic        busy;
    state_t      dbg_state;

    modport slave (
        input  exc_req, exc_code, exc_bd, exc_vpc, hwint, eret_valid,
        input  mtc0_valid, mtc0_addr, mtc0_data, sr_in, cause_in, epc_in,
        output mtc0_ready, cp0_we, cp0_addr, cp0_wdata, stall, flush,
        output pc_redirect_vld, pc_redirect, busy, dbg_state
    );

    modport master (
        output exc_req, exc_code, exc_bd, exc_vpc, hwint, eret_valid,
        output mtc0_valid, mtc0_addr, mtc0_data, sr_in, cause_in, epc_in,
        input  mtc0_ready, cp0_we, cp0_addr, cp0_wdata, stall, flush,
        input  pc_redirect_vld, pc_redirect, busy, dbg_state
    );

endinterface

// File: rtl/cp0_exc_seq.sv
// Exception-entry / ERET sequencer that owns the single CP0 write port and arbitrates mtc0.
module cp0_exc_seq
    import cp0_exc_seq_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input logic         clk,
    input logic         reset_n,
    cp0_exc_seq_if.slave bus
);

    state_t      state, state_nx;
    logic [4:0]  cap_code;
    logic        cap_bd;
    logic [5:0]  cap_hwint;
    logic [31:0] cap_epc;
    logic [31:0] vpc_adj;

    logic        we, stall, flush, rvld, ready;
    logic [4:0]  waddr;
    logic [31:0] wdata, rpc;

    // Delay-slot victims restart at the branch; the subtraction wraps mod 2^32
    assign vpc_adj = bus.exc_bd ? (bus.exc_vpc - 32'd4) : bus.exc_vpc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_code  <= '0;
            cap_bd    <= 1'b0;
            cap_hwint <= '0;
            cap_epc   <= '0;
        end else if (state == ST_IDLE && bus.exc_req) begin
            cap_code  <= bus.exc_code;
            cap_bd    <= bus.exc_bd;
            cap_hwint <= bus.hwint;
            cap_epc   <= vpc_adj & ~32'h3;
        end
    end

    always_comb begin
        state_nx = state;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        rvld     = 1'b0;
        rpc      = '0;
        ready    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.exc_req) begin
                    stall    = 1'b1;
                    state_nx = ST_E_EPC;
                end else if (bus.eret_valid) begin
                    stall    = 1'b1;
                    state_nx = ST_R_SR;
                end else if (bus.mtc0_valid) begin
                    we    = 1'b1;
                    waddr = bus.mtc0_addr;
                    wdata = bus.mtc0_data;
                    ready = 1'b1;
                end
            end
            ST_E_EPC: begin
                stall = 1'b1; we = 1'b1; waddr = CP0_EPC; wdata = cap_epc;
                state_nx = ST_E_CAUSE;
            end
            ST_E_CAUSE: begin
                stall = 1'b1; we = 1'b1; waddr = CP0_CAUSE;
                wdata = cause_merge(bus.cause_in, cap_bd, cap_hwint, cap_code);
                state_nx = ST_E_SR;
            end
            ST_E_SR: begin
                stall = 1'b1; we = 1'b1; waddr = CP0_SR; wdata = bus.sr_in | SR_EXL_MASK;
                state_nx = ST_E_JMP;
            end
            ST_E_JMP: begin
                stall = 1'b1; flush = 1'b1; rvld = 1'b1; rpc = HANDLER_PC;
                state_nx = ST_IDLE;
            end
            ST_R_SR: begin
                stall = 1'b1; we = 1'b1; waddr = CP0_SR; wdata = bus.sr_in & ~SR_EXL_MASK;
                state_nx = ST_R_JMP;
            end
            ST_R_JMP: begin
                stall = 1'b1; flush = 1'b1; rvld = 1'b1; rpc = bus.epc_in;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // The IDLE Mealy terms would otherwise leak through while reset is held
        if (!reset_n) begin
            we = 1'b0; waddr = '0; wdata = '0; stall = 1'b0;
            flush = 1'b0; rvld = 1'b0; rpc = '0; ready = 1'b0;
        end
    end

    assign bus.cp0_we          = we;
    assign bus.cp0_addr        = waddr;
    assign bus.cp0_wdata       = wdata;
    assign bus.stall           = stall;
    assign bus.flush           = flush;
    assign bus.pc_redirect_vld = rvld;
    assign bus.pc_redirect     = rpc;
    assign bus.mtc0_ready      = ready;
    assign bus.busy            = (state != ST_IDLE);
    assign bus.dbg_state       = state;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Bench for cp0_exc_seq: IDLE arbitration table, directed corner sequences, random traffic.
module tb_cp0_exc_seq;
    import cp0_exc_seq_pkg::*;

    localparam logic [31:0] HPC = 32'h0000_4180;
    localparam logic [2:0] K_EPC = 3'd0, K_CAUSE = 3'd1, K_SRSET = 3'd2,
                           K_HJMP = 3'd3, K_SRCLR = 3'd4, K_EJMP = 3'd5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   redirects = 0;

    cp0_exc_seq_if bus();
    cp0_exc_seq #(.HANDLER_PC(HPC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: pending sequence steps plus the victim details captured at acceptance
    logic [2:0]  exp_q[$];
    logic [4:0]  m_code;
    logic        m_bd;
    logic [5:0]  m_hw;
    logic [31:0] m_epc;

    typedef struct {
        logic        exc, eret, mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready, e_stall;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [74:0] act_out();
        return {bus.cp0_we, bus.cp0_addr, bus.cp0_wdata, bus.stall, bus.flush,
                bus.pc_redirect_vld, bus.pc_redirect, bus.mtc0_ready, bus.busy};
    endfunction

    function automatic logic [74:0] model_out();
        logic we = 0, st = 0, fl = 0, rv = 0, rdy = 0, bsy = 0;
        logic [4:0] a = '0;
        logic [31:0] d = '0, p = '0;
        if (exp_q.size() != 0) begin
            bsy = 1; st = 1;
            case (exp_q[0])
                K_EPC:   begin we = 1; a = 5'd14; d = m_epc; end
                K_CAUSE: begin we = 1; a = 5'd13;
                         d = {m_bd, bus.cause_in[30:16], m_hw, bus.cause_in[9:7], m_code, bus.cause_in[1:0]}; end
                K_SRSET: begin we = 1; a = 5'd12; d = bus.sr_in | 32'h2; end
                K_SRCLR: begin we = 1; a = 5'd12; d = bus.sr_in & 32'hFFFF_FFFD; end
                K_HJMP:  begin fl = 1; rv = 1; p = HPC; end
                default: begin fl = 1; rv = 1; p = bus.epc_in; end
            endcase
        end else if (bus.exc_req || bus.eret_valid) begin
            st = 1;
        end else if (bus.mtc0_valid) begin
            we = 1; a = bus.mtc0_addr; d = bus.mtc0_data; rdy = 1;
        end
        return {we, a, d, st, fl, rv, p, rdy, bsy};
    endfunction

    task automatic model_advance();
        logic [31:0] t;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (bus.exc_req) begin
            t = bus.exc_vpc - (bus.exc_bd ? 32'd4 : 32'd0);
            m_epc = {t[31:2], 2'b00};
            m_code = bus.exc_code; m_bd = bus.exc_bd; m_hw = bus.hwint;
            exp_q = '{K_EPC, K_CAUSE, K_SRSET, K_HJMP};
        end else if (bus.eret_valid) begin
            exp_q = '{K_SRCLR, K_EJMP};
        end
    endtask

    task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Inputs are set at posedge+1; compare at negedge; returns at the next posedge+1
    task automatic cycle(input string name);
        @(negedge clk);
        chk(name, act_out(), model_out());
        if (bus.pc_redirect_vld) redirects++;
        model_advance();
        @(posedge clk); #1;
    endtask

    task automatic clear_in();
        bus.exc_req = 0; bus.eret_valid = 0; bus.mtc0_valid = 0;
        bus.exc_code = 0; bus.exc_bd = 0; bus.exc_vpc = 0; bus.hwint = 0;
        bus.mtc0_addr = 0; bus.mtc0_data = 0;
    endtask

    task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] vpc, input logic [5:0] hw);
        bus.exc_req = 1; bus.exc_code = code; bus.exc_bd = bd; bus.exc_vpc = vpc; bus.hwint = hw;
    endtask

    initial begin
        clear_in();
        bus.sr_in = 0; bus.cause_in = 0; bus.epc_in = 0;
        bus.mtc0_valid = 1; bus.mtc0_addr = 5'd12; bus.mtc0_data = 32'h1234;
        #2;
        chk("reset_outputs", act_out(), 75'd0);
        clear_in();
        #10 reset_n = 1;
        @(posedge clk); #1;

        // IDLE arbitration table
        vecs[0] = '{0, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0};
        vecs[1] = '{0, 0, 1, 5'd12, 32'h0000_0401, 1, 5'd12, 32'h0000_0401, 1, 0};
        vecs[2] = '{0, 0, 1, 5'd9,  32'hDEAD_BEEF, 1, 5'd9,  32'hDEAD_BEEF, 1, 0};
        vecs[3] = '{0, 1, 1, 5'd12, 32'h5,         0, 5'd0,  32'h0,         0, 1};
        vecs[4] = '{1, 1, 1, 5'd12, 32'h5,         0, 5'd0,  32'h0,         0, 1};
        vecs[5] = '{1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 1};
        for (int i = 0; i < 6; i++) begin
            bus.exc_req = vecs[i].exc; bus.eret_valid = vecs[i].eret; bus.mtc0_valid = vecs[i].mv;
            bus.mtc0_addr = vecs[i].ma; bus.mtc0_data = vecs[i].md;
            @(negedge clk);
            chk($sformatf("tbl_%0d", i),
                {bus.cp0_we, bus.cp0_addr, bus.cp0_wdata, bus.mtc0_ready, bus.stall},
                {vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_ready, vecs[i].e_stall});
            @(posedge clk); #1;
            clear_in();
            for (int w = 0; w < 10 && bus.busy; w++) begin
                @(posedge clk); #1;
            end
            chk("tbl_back_idle", bus.busy, 0);
        end

        // Interrupt entry
        bus.sr_in = 32'h0000_FC01; bus.cause_in = 32'h0;
        exc(5'd0, 0, 32'h0000_3010, 6'b000100);
        cycle("int_acc"); clear_in();
        chk("int_epc", {bus.cp0_we, bus.cp0_addr, bus.cp0_wdata}, {1'b1, 5'd14, 32'h0000_3010});
        cycle("int_s1");
        chk("int_cause", {bus.cp0_addr, bus.cp0_wdata}, {5'd13, 32'h0000_1000});
        cycle("int_s2");
        chk("int_sr", {bus.cp0_addr, bus.cp0_wdata}, {5'd12, 32'h0000_FC03});
        cycle("int_s3");
        chk("int_jmp", {bus.flush, bus.pc_redirect_vld, bus.pc_redirect}, {2'b11, 32'h0000_4180});
        cycle("int_s4");
        chk("int_idle", bus.busy, 0);

        // Delay-slot exception
        exc(5'd4, 1, 32'h0000_3024, 6'b0);
        cycle("ds_acc"); clear_in();
        chk("ds_epc", bus.cp0_wdata, 32'h0000_3020);
        cycle("ds_s1");
        chk("ds_cause", bus.cp0_wdata, 32'h8000_0010);
        for (int i = 0; i < 3; i++) cycle("ds_tail");

        // ERET
        bus.sr_in = 32'h0000_FC03; bus.epc_in = 32'h0000_3020; bus.eret_valid = 1;
        cycle("eret_acc"); clear_in();
        chk("eret_sr", {bus.cp0_we, bus.cp0_addr, bus.cp0_wdata}, {1'b1, 5'd12, 32'h0000_FC01});
        cycle("eret_s1");
        chk("eret_jmp", {bus.flush, bus.pc_redirect_vld, bus.pc_redirect}, {2'b11, 32'h0000_3020});
        cycle("eret_s2");
        chk("eret_idle", bus.busy, 0);

        // Collision: exception wins, mtc0 held until IDLE
        exc(5'd8, 0, 32'h0000_0100, 6'b0);
        bus.eret_valid = 1; bus.mtc0_valid = 1; bus.mtc0_addr = 5'd12; bus.mtc0_data = 32'h401;
        cycle("col_acc");
        bus.exc_req = 0; bus.eret_valid = 0;
        for (int i = 0; i < 4; i++) cycle("col_busy");
        chk("col_mtc0", {bus.cp0_we, bus.cp0_addr, bus.cp0_wdata, bus.mtc0_ready}, {1'b1, 5'd12, 32'h401, 1'b1});
        cycle("col_mtc0_cyc"); clear_in();

        // EPC wrap at address 0 in a delay slot
        exc(5'd10, 1, 32'h0, 6'b0);
        cycle("wrap_acc"); clear_in();
        chk("wrap_epc", bus.cp0_wdata, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) cycle("wrap_tail");

        // Request pulse during E_SR is dropped: one redirect only
        redirects = 0;
        exc(5'd12, 0, 32'h0000_2000, 6'b0);
        cycle("drop_acc"); clear_in();
        cycle("drop_epc"); cycle("drop_cause");
        exc(5'd13, 0, 32'h0000_5000, 6'b0);
        cycle("drop_sr"); clear_in();
        for (int i = 0; i < 4; i++) cycle("drop_tail");
        chk("drop_redirects", redirects, 1);

        // Reset during E_CAUSE
        exc(5'd4, 0, 32'h0000_6000, 6'b0);
        cycle("rst_acc"); clear_in();
        cycle("rst_epc");
        bus.mtc0_valid = 1; bus.mtc0_addr = 5'd12; bus.mtc0_data = 32'h77;
        #2 reset_n = 0;
        #1 chk("rst_async_zero", act_out(), 75'd0);
        exp_q.delete();
        @(negedge clk); reset_n = 1;
        bus.mtc0_valid = 0;
        @(posedge clk); #1;
        chk("rst_idle", {bus.busy, bus.dbg_state}, {1'b0, ST_IDLE});

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.exc_req = ($urandom_range(0, 7) == 0);
            bus.exc_code = 5'($urandom); bus.exc_bd = 1'($urandom);
            bus.exc_vpc = $urandom; bus.hwint = 6'($urandom);
            bus.eret_valid = ($urandom_range(0, 5) == 0);
            bus.mtc0_valid = 1'($urandom); bus.mtc0_addr = 5'($urandom); bus.mtc0_data = $urandom;
            bus.sr_in = $urandom; bus.cause_in = $urandom; bus.epc_in = $urandom;
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
